// File: rtl/calc_sequencer_if.sv
// Key-event strobes into the calculator sequencer and its control pulses/status out.
// master = key/opcode encoders and ALU flag side; slave = the sequencer itself.
interface calc_sequencer_if;
  logic       digit_strobe;
  logic       op_strobe;
  logic [2:0] op_in;
  logic       enter_strobe;
  logic       clear_strobe;
  logic       o_flag;

  logic       store_digit;
  logic       enter;
  logic       result_ready;
  logic [2:0] opcode;
  logic       busy;
  logic       error;
  logic [2:0] state;

  modport master (
    output digit_strobe, op_strobe, op_in, enter_strobe, clear_strobe, o_flag,
    input  store_digit, enter, result_ready, opcode, busy, error, state
  );

  modport slave (
    input  digit_strobe, op_strobe, op_in, enter_strobe, clear_strobe, o_flag,
    output store_digit, enter, result_ready, opcode, busy, error, state
  );
endinterface

// File: rtl/calc_sequencer.sv
// Keypad calculator control FSM: turns key strobes into store_digit/enter/result_ready
// pulses, holds the ALU opcode, limits operand length and traps ALU overflow.
module calc_sequencer #(
  parameter int MAX_DIGITS = 3,
  parameter int ALU_LAT    = 2
) (
  input  logic               clk,
  input  logic               nrst,
  calc_sequencer_if.slave    bus
);

  localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
  localparam int WAIT_W = $clog2(ALU_LAT + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(ALU_LAT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_OP1   = 3'd1;
  localparam logic [2:0] S_OPSEL = 3'd2;
  localparam logic [2:0] S_OP2   = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]        cur_state, nxt_state;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_nx;
  logic [2:0]        opcode_q, opcode_nx;
  logic              store_q, store_nx;
  logic              enter_q, enter_nx;
  logic              result_q, result_nx;

  logic ev_clr, ev_ent, ev_op, ev_dig;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  function automatic logic [WAIT_W-1:0] sat_dec(input logic [WAIT_W-1:0] v);
    return (v == '0) ? '0 : v - WAIT_ONE;
  endfunction

  // Strobe arbitration: a single winner per cycle, losers are discarded.
  assign ev_clr = bus.clear_strobe;
  assign ev_ent = bus.enter_strobe & ~bus.clear_strobe;
  assign ev_op  = bus.op_strobe & ~bus.enter_strobe & ~bus.clear_strobe;
  assign ev_dig = bus.digit_strobe & ~bus.op_strobe & ~bus.enter_strobe & ~bus.clear_strobe;

  always_comb begin
    nxt_state = cur_state;
    cnt_nx    = cnt;
    wait_nx   = wait_cnt;
    opcode_nx = opcode_q;
    store_nx  = 1'b0;
    enter_nx  = 1'b0;
    result_nx = 1'b0;

    if (ev_clr) begin
      nxt_state = S_IDLE;
      cnt_nx    = '0;
      wait_nx   = '0;
      opcode_nx = 3'b000;
    end else begin
      case (cur_state)
        S_IDLE: begin
          if (ev_dig) begin
            store_nx  = 1'b1;
            cnt_nx    = CNT_ONE;
            nxt_state = S_OP1;
          end
        end
        S_OP1, S_OP2: begin
          if (ev_dig && (cnt < CNT_MAX)) begin
            store_nx = 1'b1;
            cnt_nx   = sat_inc(cnt);
          end else if (ev_op && (cur_state == S_OP1)) begin
            opcode_nx = bus.op_in;
            enter_nx  = 1'b1;
            cnt_nx    = '0;
            nxt_state = S_OPSEL;
          end else if (ev_ent && (cur_state == S_OP2)) begin
            wait_nx   = WAIT_INIT;
            nxt_state = S_EXEC;
          end
        end
        S_OPSEL: begin
          if (ev_op) begin
            opcode_nx = bus.op_in;
          end else if (ev_dig) begin
            store_nx  = 1'b1;
            cnt_nx    = CNT_ONE;
            nxt_state = S_OP2;
          end
        end
        S_EXEC: begin
          wait_nx = sat_dec(wait_cnt);
          // The last wait cycle is the one where the ALU flag is trusted.
          if (wait_cnt <= WAIT_ONE) begin
            if (bus.o_flag) begin
              nxt_state = S_ERR;
            end else begin
              result_nx = 1'b1;
              nxt_state = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (ev_op) begin
            opcode_nx = bus.op_in;
            enter_nx  = 1'b1;
            cnt_nx    = '0;
            nxt_state = S_OPSEL;
          end else if (ev_dig) begin
            store_nx  = 1'b1;
            cnt_nx    = CNT_ONE;
            nxt_state = S_OP1;
          end
        end
        S_ERR: begin
          nxt_state = S_ERR;
        end
        default: begin
          nxt_state = S_IDLE;
          cnt_nx    = '0;
          wait_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur_state <= S_IDLE;
      cnt       <= '0;
      wait_cnt  <= '0;
      opcode_q  <= 3'b000;
      store_q   <= 1'b0;
      enter_q   <= 1'b0;
      result_q  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= cnt_nx;
      wait_cnt  <= wait_nx;
      opcode_q  <= opcode_nx;
      store_q   <= store_nx;
      enter_q   <= enter_nx;
      result_q  <= result_nx;
    end
  end

  assign bus.store_digit  = store_q;
  assign bus.enter        = enter_q;
  assign bus.result_ready = result_q;
  assign bus.opcode       = opcode_q;
  assign bus.busy         = (cur_state == S_EXEC);
  assign bus.error        = (cur_state == S_ERR);
  assign bus.state        = cur_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: expected control pulses are queued when a key is
// driven and matched against the DUT pulses as they appear.
module tb_calc_sequencer;

  localparam logic [2:0] ADD = 3'd1;
  localparam logic [2:0] SUB = 3'd2;
  localparam logic [2:0] MUL = 3'd3;

  localparam logic [2:0] P_NONE   = 3'b000;
  localparam logic [2:0] P_STORE  = 3'b100;
  localparam logic [2:0] P_ENTER  = 3'b010;
  localparam logic [2:0] P_RESULT = 3'b001;

  typedef struct {
    logic [2:0] pulses;
    int         due;
    logic [2:0] opc;
  } exp_t;

  logic clk = 1'b0;
  logic nrst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  calc_sequencer_if bus();

  calc_sequencer #(.MAX_DIGITS(3), .ALU_LAT(2)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every pulse the DUT raises must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [2:0] seen;
    exp_t e;
    seen = {bus.store_digit, bus.enter, bus.result_ready};
    if (seen !== P_NONE) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {29'd0, seen}, {29'd0, P_NONE});
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {29'd0, seen}, {29'd0, e.pulses});
        chk("pulse_cycle", cyc, e.due);
        chk("pulse_opcode", {29'd0, bus.opcode}, {29'd0, e.opc});
      end
    end
  end

  task automatic push_exp(input logic [2:0] p, input int due, input logic [2:0] opc);
    exp_t e;
    e.pulses = p;
    e.due    = due;
    e.opc    = opc;
    sb.push_back(e);
  endtask

  task automatic step(input logic d, input logic o, input logic [2:0] ov, input logic e,
                      input logic c, input logic [2:0] exp_p, input logic [2:0] exp_opc);
    @(negedge clk);
    bus.digit_strobe = d;
    bus.op_strobe    = o;
    bus.op_in        = ov;
    bus.enter_strobe = e;
    bus.clear_strobe = c;
    if (exp_p != P_NONE) push_exp(exp_p, cyc + 1, exp_opc);
    @(posedge clk);
    #1;
    bus.digit_strobe = 1'b0;
    bus.op_strobe    = 1'b0;
    bus.op_in        = 3'd0;
    bus.enter_strobe = 1'b0;
    bus.clear_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst             = 1'b0;
    bus.digit_strobe = 1'b0;
    bus.op_strobe    = 1'b0;
    bus.op_in        = 3'd0;
    bus.enter_strobe = 1'b0;
    bus.clear_strobe = 1'b0;
    bus.o_flag       = 1'b0;
    idle(2);
    chk("rst_state", {29'd0, bus.state}, 32'd0);
    chk("rst_opcode", {29'd0, bus.opcode}, 32'd0);
    chk("rst_busy_err", {30'd0, bus.busy, bus.error}, 32'd0);
    chk("rst_pulses", {29'd0, bus.store_digit, bus.enter, bus.result_ready}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    idle(1);

    // T6 part: enter in IDLE does nothing
    step(0, 0, 3'd0, 1, 0, P_NONE, 3'd0);
    chk("idle_enter_state", {29'd0, bus.state}, 32'd0);

    // T2: three digits accepted, fourth dropped, then ADD
    step(1, 0, 3'd0, 0, 0, P_STORE, 3'd0);
    chk("op1_state", {29'd0, bus.state}, 32'd1);
    step(1, 0, 3'd0, 0, 0, P_STORE, 3'd0);
    step(1, 0, 3'd0, 0, 0, P_STORE, 3'd0);
    step(1, 0, 3'd0, 0, 0, P_NONE, 3'd0);
    step(0, 0, 3'd0, 1, 0, P_NONE, 3'd0);
    chk("op1_enter_ignored", {29'd0, bus.state}, 32'd1);
    step(0, 1, ADD, 0, 0, P_ENTER, ADD);
    chk("t2_state", {29'd0, bus.state}, 32'd2);
    chk("t2_opcode", {29'd0, bus.opcode}, {29'd0, ADD});

    // T6: op twice in OPSEL, enter ignored
    step(0, 1, MUL, 0, 0, P_NONE, 3'd0);
    chk("t6_opcode_mul", {29'd0, bus.opcode}, {29'd0, MUL});
    step(0, 1, ADD, 0, 0, P_NONE, 3'd0);
    step(0, 0, 3'd0, 1, 0, P_NONE, 3'd0);
    chk("t6_opcode_add", {29'd0, bus.opcode}, {29'd0, ADD});
    chk("t6_state", {29'd0, bus.state}, 32'd2);

    // T3: second operand, '=', result after ALU_LAT cycles, then chain with SUB
    step(1, 0, 3'd0, 0, 0, P_STORE, ADD);
    chk("op2_state", {29'd0, bus.state}, 32'd3);
    step(0, 1, SUB, 0, 0, P_NONE, 3'd0);
    chk("op2_op_ignored", {29'd0, bus.opcode}, {29'd0, ADD});
    step(0, 0, 3'd0, 1, 0, P_NONE, 3'd0);
    chk("exec_state", {29'd0, bus.state}, 32'd4);
    chk("exec_busy", {31'd0, bus.busy}, 32'd1);
    push_exp(P_RESULT, cyc + 2, ADD);
    step(1, 1, MUL, 0, 0, P_NONE, 3'd0);
    chk("exec_hold_state", {29'd0, bus.state}, 32'd4);
    chk("exec_hold_opcode", {29'd0, bus.opcode}, {29'd0, ADD});
    idle(1);
    chk("done_state", {29'd0, bus.state}, 32'd5);
    chk("done_busy", {31'd0, bus.busy}, 32'd0);
    step(0, 0, 3'd0, 1, 0, P_NONE, 3'd0);
    chk("done_enter_ignored", {29'd0, bus.state}, 32'd5);
    step(0, 1, SUB, 0, 0, P_ENTER, SUB);
    chk("chain_state", {29'd0, bus.state}, 32'd2);

    // T4: overflow flag raised only in the sampling cycle
    step(0, 0, 3'd0, 0, 1, P_NONE, 3'd0);
    chk("clr_state", {29'd0, bus.state}, 32'd0);
    chk("clr_opcode", {29'd0, bus.opcode}, 32'd0);
    step(1, 0, 3'd0, 0, 0, P_STORE, 3'd0);
    step(0, 1, MUL, 0, 0, P_ENTER, MUL);
    step(1, 0, 3'd0, 0, 0, P_STORE, MUL);
    step(0, 0, 3'd0, 1, 0, P_NONE, 3'd0);
    idle(1);
    bus.o_flag = 1'b1;
    idle(1);
    bus.o_flag = 1'b0;
    chk("err_state", {29'd0, bus.state}, 32'd6);
    chk("err_flag", {31'd0, bus.error}, 32'd1);
    step(1, 0, 3'd0, 0, 0, P_NONE, 3'd0);
    step(0, 1, ADD, 0, 0, P_NONE, 3'd0);
    step(0, 0, 3'd0, 1, 0, P_NONE, 3'd0);
    chk("err_sticky", {29'd0, bus.state}, 32'd6);
    chk("err_opcode_held", {29'd0, bus.opcode}, {29'd0, MUL});
    step(0, 0, 3'd0, 0, 1, P_NONE, 3'd0);
    chk("err_clr_state", {29'd0, bus.state}, 32'd0);
    chk("err_clr_flag", {31'd0, bus.error}, 32'd0);

    // Flag high only in the first EXEC cycle must not be sampled; then DONE -> new calc
    step(1, 0, 3'd0, 0, 0, P_STORE, 3'd0);
    step(0, 1, ADD, 0, 0, P_ENTER, ADD);
    step(1, 0, 3'd0, 0, 0, P_STORE, ADD);
    step(0, 0, 3'd0, 1, 0, P_NONE, 3'd0);
    push_exp(P_RESULT, cyc + 2, ADD);
    bus.o_flag = 1'b1;
    idle(1);
    bus.o_flag = 1'b0;
    idle(1);
    chk("early_flag_done", {29'd0, bus.state}, 32'd5);
    step(1, 0, 3'd0, 0, 0, P_STORE, ADD);
    chk("done_digit_state", {29'd0, bus.state}, 32'd1);

    // T5: clear beats digit, op beats digit
    step(1, 0, 3'd0, 0, 1, P_NONE, 3'd0);
    chk("t5_clr_state", {29'd0, bus.state}, 32'd0);
    step(1, 0, 3'd0, 0, 0, P_STORE, 3'd0);
    step(1, 1, SUB, 0, 0, P_ENTER, SUB);
    chk("t5_op_state", {29'd0, bus.state}, 32'd2);

    // Clear aborts EXEC without a result
    step(1, 0, 3'd0, 0, 0, P_STORE, SUB);
    step(0, 0, 3'd0, 1, 0, P_NONE, 3'd0);
    step(0, 0, 3'd0, 0, 1, P_NONE, 3'd0);
    idle(2);
    chk("abort_state", {29'd0, bus.state}, 32'd0);

    // T1: asynchronous reset in the middle of EXEC
    step(1, 0, 3'd0, 0, 0, P_STORE, 3'd0);
    step(0, 1, ADD, 0, 0, P_ENTER, ADD);
    step(1, 0, 3'd0, 0, 0, P_STORE, ADD);
    step(0, 0, 3'd0, 1, 0, P_NONE, 3'd0);
    #2;
    nrst = 1'b0;
    #1;
    chk("t1_async_state", {29'd0, bus.state}, 32'd0);
    chk("t1_async_busy", {31'd0, bus.busy}, 32'd0);
    chk("t1_async_opcode", {29'd0, bus.opcode}, 32'd0);
    idle(1);
    @(negedge clk);
    nrst = 1'b1;
    idle(3);
    chk("t1_release_state", {29'd0, bus.state}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
